vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Parametrised VGA raster timing generator. Successor to the fixed 640x480 signal generator.
- Adds: async reset, pixel clock-enable, per-axis porch/sync/polarity parameters, exact 0-based wrap, one-stage output register with all outputs aligned, line/frame start strobes.
- Sits between the pixel clock domain and the pixel/colour pipeline. Feeds hs/vs to the connector and blank/hcount/vcount to the pixel renderer.

Parameters:
- H_ACTIVE, 640, visible columns
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, active level of hs
- VS_POL, 0, active level of vs
- CW, 11, width of hcount/vcount
- AW, 19, width of pix_addr (optional feature only)

Ports:
- pixel_clk  in  1  pixel clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- ce  in  1  pixel enable; timing advances only on cycles with ce=1
- hs  out  1  horizontal sync, registered
- vs  out  1  vertical sync, registered
- blank  out  1  1 outside the active area, registered
- hcount  out  CW  column of the presented pixel, 0..H_TOTAL-1
- vcount  out  CW  line of the presented pixel, 0..V_TOTAL-1
- line_start  out  1  one-clock strobe: presented pixel has hcount=0
- frame_start  out  1  one-clock strobe: presented pixel is (0,0)
- pix_addr  out  AW  linear framebuffer address (only with VGA_TIMING_PIXEL_ADDR_EN)

Behaviour:
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Internal counters h_cnt and v_cnt. On ce=1:
  - h_cnt increments. At H_TOTAL-1 it wraps to 0 and v_cnt advances.
  - v_cnt wraps to 0 at V_TOTAL-1 when h_cnt also wraps.
- Output stage, loaded on ce=1 from the current h_cnt/v_cnt (latency 1 clock; all outputs describe the same pixel):
  - hcount <= h_cnt, vcount <= v_cnt
  - blank <= !(h_cnt<H_ACTIVE && v_cnt<V_ACTIVE)
  - hs <= HS_POL when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC; otherwise ~HS_POL
  - vs <= VS_POL when V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC; otherwise ~VS_POL
  - vs is evaluated per pixel against v_cnt, so it changes at the hcount=0 boundary.
- Strobes:
  - line_start <= ce && h_cnt==0
  - frame_start <= ce && h_cnt==0 && v_cnt==0
  - Both are forced to 0 on any ce=0 cycle. They are never wider than one clock.
- ce=0: counters and all level outputs hold.
- Reset, asserted at any time including mid-line:
  - Counters go to 0 immediately.
  - hcount=0, vcount=0, hs=~HS_POL, vs=~VS_POL, blank=1, line_start=0, frame_start=0, pix_addr=0.
- First ce after reset deassertion presents (0,0): blank=0, line_start=1, frame_start=1.
- Elaboration check (simulation error):
  - 2^CW must exceed both H_TOTAL-1 and V_TOTAL-1.
  - Every porch/sync parameter must be >=1.

Optional Feature:
- Macro: VGA_TIMING_PIXEL_ADDR_EN.
- Defined: pix_addr port exists.
  - Computed incrementally, with no multiplier.
  - When blank=0, equals vcount*H_ACTIVE+hcount.
  - During blanking, holds the address of the next visible pixel.
  - Returns to 0 at frame_start.
  - Reset value 0. Requires 2^AW >= H_ACTIVE*V_ACTIVE.
- Undefined: pix_addr port and its logic are absent; all other behaviour is unchanged.

Decomposition:
- Package vga_timing_pkg:
  - Default 640x480@60 constants.
  - Derived H_TOTAL/V_TOTAL functions.
  - Sync polarity constants (SYNC_ACTIVE_LOW=0).
- Sub-module vga_axis_timer:
  - One counter with wrap, active flag and sync-region flag.
  - Inputs: tick. Outputs: wrap.
  - Instantiated twice: H ticked by ce, V ticked by the H wrap.

Test Plan:
- Defaults, ce=1, 2 frames -> line period 800 clocks; hs=0 exactly for hcount 656..751; vs=0 exactly for vcount 490..491; 307200 blank=0 cycles per frame; frame_start every 420000 clocks.
- ce high 1 clock in 4 -> line period 3200 clocks; outputs hold between enables; strobes 1 clock wide.
- Reset asserted at hcount=300, vcount=200 -> next clock all outputs at reset values; first ce after release gives hcount=0, vcount=0, frame_start=1.
- H_ACTIVE=4, H_FP=1, H_SYNC=1, H_BP=1, V_ACTIVE=2, V_FP=V_SYNC=V_BP=1 -> hcount sequence 0..6 wraps to 0; vcount 0..4 wraps to 0; blank=0 only for hcount<4 and vcount<2.
- HS_POL=1, VS_POL=1 -> hs=1 only for hcount 656..751; idle level 0 after reset.
- VGA_TIMING_PIXEL_ADDR_EN defined -> pix_addr=640 at (0,1); 307199 at (639,479); holds 307200 through vertical blank; 0 at next frame_start.

Source files
------------

// File: rtl/vga_timing_gen_pkg.sv
// vga_timing_pkg: shared constants and helpers for the VGA raster timing generator.
//   - default 640x480@60 axis parameters
//   - sync polarity constants
//   - axis_total / h_total / v_total: derived period of one axis
package vga_timing_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam logic SYNC_ACTIVE_LOW  = 1'b0;
  localparam logic SYNC_ACTIVE_HIGH = 1'b1;

  function automatic int axis_total(input int active, input int fp, input int sync,
                                    input int bp);
    return active + fp + sync + bp;
  endfunction

  function automatic int h_total(input int active, input int fp, input int sync,
                                 input int bp);
    return axis_total(active, fp, sync, bp);
  endfunction

  function automatic int v_total(input int active, input int fp, input int sync,
                                 input int bp);
    return axis_total(active, fp, sync, bp);
  endfunction

endpackage

// File: rtl/vga_axis_timer.sv
// vga_axis_timer: one raster axis (horizontal or vertical).
// Ports:
//   pixel_clk, rst  clock, async active-high reset
//   tick            advance the counter by one position
//   cnt             current position, 0..TOTAL-1
//   wrap            tick while at TOTAL-1 (counter returns to 0 on this edge)
//   active          cnt lies in the visible region
//   sync_region     cnt lies in the sync pulse region
module vga_axis_timer
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE = DEF_H_ACTIVE,
  parameter int FP     = DEF_H_FP,
  parameter int SYNC   = DEF_H_SYNC,
  parameter int BP     = DEF_H_BP,
  parameter int CW     = 11
) (
  input  logic          pixel_clk,
  input  logic          rst,
  input  logic          tick,
  output logic [CW-1:0] cnt,
  output logic          wrap,
  output logic          active,
  output logic          sync_region
);

  localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);

  localparam logic [CW-1:0] LAST       = CW'(TOTAL - 1);
  localparam logic [CW-1:0] ACT_END    = CW'(ACTIVE);
  localparam logic [CW-1:0] SYNC_START = CW'(ACTIVE + FP);
  localparam logic [CW-1:0] SYNC_END   = CW'(ACTIVE + FP + SYNC);
  localparam logic [CW-1:0] ONE        = CW'(1);

  if ((TOTAL - 1) >= (1 << CW)) begin : g_bad_cw
    $error("vga_axis_timer: CW=%0d too narrow for total %0d", CW, TOTAL);
  end
  if (FP < 1 || SYNC < 1 || BP < 1) begin : g_bad_porch
    $error("vga_axis_timer: porch/sync widths must be >= 1");
  end

  assign wrap        = tick && (cnt == LAST);
  assign active      = (cnt < ACT_END);
  assign sync_region = (cnt >= SYNC_START) && (cnt < SYNC_END);

  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= wrap ? '0 : cnt + ONE;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing generator.
// Ports:
//   pixel_clk, rst   clock, async active-high reset
//   ce               pixel enable; timing advances only when ce=1
//   hs, vs           registered sync outputs (active level HS_POL / VS_POL)
//   blank            1 outside the visible area
//   hcount, vcount   position of the presented pixel
//   line_start       one-clock strobe, presented pixel has hcount=0
//   frame_start      one-clock strobe, presented pixel is (0,0)
//   pix_addr         linear framebuffer address; present only when the
//                    macro VGA_TIMING_PIXEL_ADDR_EN is defined
// All outputs come from one register stage loaded on ce, so every output
// describes the same pixel, one clock after the counters held it.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int   H_ACTIVE = DEF_H_ACTIVE,
  parameter int   H_FP     = DEF_H_FP,
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BP     = DEF_H_BP,
  parameter int   V_ACTIVE = DEF_V_ACTIVE,
  parameter int   V_FP     = DEF_V_FP,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BP     = DEF_V_BP,
  parameter logic HS_POL   = SYNC_ACTIVE_LOW,
  parameter logic VS_POL   = SYNC_ACTIVE_LOW,
  parameter int   CW       = 11,
  parameter int   AW       = 19
) (
  input  logic          pixel_clk,
  input  logic          rst,
  input  logic          ce,
  output logic          hs,
  output logic          vs,
  output logic          blank,
  output logic [CW-1:0] hcount,
  output logic [CW-1:0] vcount,
  output logic          line_start,
  output logic          frame_start
`ifdef VGA_TIMING_PIXEL_ADDR_EN
  ,
  output logic [AW-1:0] pix_addr
`endif
);

  logic [CW-1:0] h_cnt, v_cnt;
  logic          h_wrap, v_wrap;
  logic          h_active, v_active;
  logic          h_sync, v_sync;
  // Set while the counters sit at (0,0); cheaper than a double compare.
  logic          at_origin;

  vga_axis_timer #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .CW(CW)
  ) u_h (
    .pixel_clk  (pixel_clk),
    .rst        (rst),
    .tick       (ce),
    .cnt        (h_cnt),
    .wrap       (h_wrap),
    .active     (h_active),
    .sync_region(h_sync)
  );

  vga_axis_timer #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .CW(CW)
  ) u_v (
    .pixel_clk  (pixel_clk),
    .rst        (rst),
    .tick       (h_wrap),
    .cnt        (v_cnt),
    .wrap       (v_wrap),
    .active     (v_active),
    .sync_region(v_sync)
  );

  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      at_origin <= 1'b1;
    end else if (ce) begin
      at_origin <= v_wrap;
    end
  end

  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      hcount      <= '0;
      vcount      <= '0;
      hs          <= ~HS_POL;
      vs          <= ~VS_POL;
      blank       <= 1'b1;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (ce) begin
      hcount      <= h_cnt;
      vcount      <= v_cnt;
      hs          <= h_sync ? HS_POL : ~HS_POL;
      vs          <= v_sync ? VS_POL : ~VS_POL;
      blank       <= !(h_active && v_active);
      line_start  <= (h_cnt == '0);
      frame_start <= at_origin;
    end else begin
      // Strobes must never stretch across a disabled cycle.
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

`ifdef VGA_TIMING_PIXEL_ADDR_EN
  if ((1 << AW) < (H_ACTIVE * V_ACTIVE)) begin : g_bad_aw
    $error("vga_timing_gen: AW=%0d too narrow for %0d pixels", AW, H_ACTIVE * V_ACTIVE);
  end

  // The address steps by one after each visible pixel has been presented
  // (blank=0 in the output register), so through blanking it already holds
  // the address of the next visible pixel.
  always_ff @(posedge pixel_clk or posedge rst) begin
    if (rst) begin
      pix_addr <= '0;
    end else if (ce) begin
      if (at_origin) begin
        pix_addr <= '0;
      end else if (!blank) begin
        pix_addr <= pix_addr + AW'(1);
      end
    end
  end
`else
  if (AW < 1) begin : g_bad_aw
    $error("vga_timing_gen: AW must be >= 1");
  end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: a default-size instance, a high-polarity
// instance sharing its reset/enable, and a tiny 7x5 raster instance.
// Outputs are sampled 1 time unit after each rising clock edge; inputs are
// changed at the same point so they are stable well before the next edge.
module tb_vga_timing_gen;

  logic pixel_clk = 1'b0;
  logic rst_a = 1'b1, ce_a = 1'b0;
  logic rst_b = 1'b1, ce_b = 1'b0;

  logic        hs_d, vs_d, blank_d, ls_d, fs_d;
  logic [10:0] hc_d, vc_d;
  logic        hs_p, vs_p, blank_p, ls_p, fs_p;
  logic [10:0] hc_p, vc_p;
  logic        hs_s, vs_s, blank_s, ls_s, fs_s;
  logic [10:0] hc_s, vc_s;
`ifdef VGA_TIMING_PIXEL_ADDR_EN
  logic [18:0] pa_d, pa_p, pa_s;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 pixel_clk = ~pixel_clk;

  vga_timing_gen dut_def (
    .pixel_clk(pixel_clk), .rst(rst_a), .ce(ce_a),
    .hs(hs_d), .vs(vs_d), .blank(blank_d), .hcount(hc_d), .vcount(vc_d),
    .line_start(ls_d), .frame_start(fs_d)
`ifdef VGA_TIMING_PIXEL_ADDR_EN
    , .pix_addr(pa_d)
`endif
  );

  vga_timing_gen #(.HS_POL(1'b1), .VS_POL(1'b1)) dut_pol (
    .pixel_clk(pixel_clk), .rst(rst_a), .ce(ce_a),
    .hs(hs_p), .vs(vs_p), .blank(blank_p), .hcount(hc_p), .vcount(vc_p),
    .line_start(ls_p), .frame_start(fs_p)
`ifdef VGA_TIMING_PIXEL_ADDR_EN
    , .pix_addr(pa_p)
`endif
  );

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1)
  ) dut_small (
    .pixel_clk(pixel_clk), .rst(rst_b), .ce(ce_b),
    .hs(hs_s), .vs(vs_s), .blank(blank_s), .hcount(hc_s), .vcount(vc_s),
    .line_start(ls_s), .frame_start(fs_s)
`ifdef VGA_TIMING_PIXEL_ADDR_EN
    , .pix_addr(pa_s)
`endif
  );

  // Vector layout: {hcount, vcount, blank, hs, vs, line_start, frame_start}
  function automatic logic [26:0] pack(input int h, input int v, input logic b,
                                       input logic h_s, input logic v_s,
                                       input logic l, input logic f);
    return {11'(h), 11'(v), b, h_s, v_s, l, f};
  endfunction

  task automatic step();
    @(posedge pixel_clk);
    #1;
  endtask

  task automatic do_reset_a();
    ce_a  = 1'b0;
    rst_a = 1'b1;
    step();
    rst_a = 1'b0;
  endtask

  task automatic test_reset();
    logic [26:0] got, exp;
    rst_a = 1'b1;
    ce_a  = 1'b1;
    repeat (3) step();
    got = {hc_d, vc_d, blank_d, hs_d, vs_d, ls_d, fs_d};
    exp = pack(0, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL reset_def got %h want %h", got, exp);
    end
    got = {hc_p, vc_p, blank_p, hs_p, vs_p, ls_p, fs_p};
    exp = pack(0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL reset_pol got %h want %h", got, exp);
    end
    rst_a = 1'b0;
    step();
    got = {hc_d, vc_d, blank_d, hs_d, vs_d, ls_d, fs_d};
    exp = pack(0, 0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL first_ce got %h want %h", got, exp);
    end
  endtask

  // Two full default lines: hs low for 656..751, line period 800.
  task automatic test_line();
    logic [26:0] got, exp;
    int h, v;
    do_reset_a();
    ce_a = 1'b1;
    for (int k = 0; k < 1600; k++) begin
      step();
      h = k % 800;
      v = k / 800;
      got = {hc_d, vc_d, blank_d, hs_d, vs_d, ls_d, fs_d};
      exp = pack(h, v, !(h < 640), !(h >= 656 && h < 752), 1'b1, h == 0, k == 0);
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL line_def k=%0d got %h want %h", k, got, exp);
      end
      got = {hc_p, vc_p, blank_p, hs_p, vs_p, ls_p, fs_p};
      exp = pack(h, v, !(h < 640), (h >= 656 && h < 752), 1'b0, h == 0, k == 0);
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL line_pol k=%0d got %h want %h", k, got, exp);
      end
`ifdef VGA_TIMING_PIXEL_ADDR_EN
      n_cmp++;
      if (pa_d !== 19'(v * 640 + ((h < 640) ? h : 640))) begin
        n_err++;
        $display("FAIL addr_def k=%0d got %0d want %0d", k, pa_d,
                 v * 640 + ((h < 640) ? h : 640));
      end
`endif
    end
  endtask

  // ce high one clock in four: outputs hold, strobes one clock wide,
  // line period 3200 clocks.
  task automatic test_ce_quarter();
    logic [26:0] got, exp;
    int n_en, p, h, v, ls_cnt, ls_first, ls_second;
    do_reset_a();
    n_en = 0;
    ls_cnt = 0;
    ls_first = -1;
    ls_second = -1;
    for (int i = 0; i < 6400; i++) begin
      ce_a = (i % 4 == 0);
      step();
      if (ce_a) n_en++;
      p = n_en - 1;
      h = p % 800;
      v = p / 800;
      got = {hc_d, vc_d, blank_d, hs_d, vs_d, ls_d, fs_d};
      exp = pack(h, v, !(h < 640), !(h >= 656 && h < 752), 1'b1,
                 ce_a && h == 0, ce_a && p == 0);
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL ce_quarter i=%0d got %h want %h", i, got, exp);
      end
      if (ls_d === 1'b1) begin
        ls_cnt++;
        if (ls_first < 0) ls_first = i;
        else if (ls_second < 0) ls_second = i;
      end
    end
    ce_a = 1'b0;
    n_cmp++;
    if (ls_cnt != 2 || (ls_second - ls_first) != 3200) begin
      n_err++;
      $display("FAIL ce_quarter_period got count %0d period %0d want 2 / 3200",
               ls_cnt, ls_second - ls_first);
    end
  endtask

  // Reset asserted mid-line acts without waiting for a clock edge.
  task automatic test_reset_mid();
    logic [26:0] got, exp;
    do_reset_a();
    ce_a = 1'b1;
    repeat (301) step();
    n_cmp++;
    if (hc_d !== 11'd300) begin
      n_err++;
      $display("FAIL mid_pos got %0d want 300", hc_d);
    end
    rst_a = 1'b1;
    #1;
    exp = pack(0, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    got = {hc_d, vc_d, blank_d, hs_d, vs_d, ls_d, fs_d};
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL mid_reset_async got %h want %h", got, exp);
    end
    step();
    got = {hc_d, vc_d, blank_d, hs_d, vs_d, ls_d, fs_d};
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL mid_reset_held got %h want %h", got, exp);
    end
    rst_a = 1'b0;
    ce_a  = 1'b0;
    repeat (2) step();
    got = {hc_d, vc_d, blank_d, hs_d, vs_d, ls_d, fs_d};
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL mid_idle_hold got %h want %h", got, exp);
    end
    ce_a = 1'b1;
    step();
    got = {hc_d, vc_d, blank_d, hs_d, vs_d, ls_d, fs_d};
    exp = pack(0, 0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL mid_first_ce got %h want %h", got, exp);
    end
    ce_a = 1'b0;
  endtask

  // 7x5 raster, two frames: every position, vs on line 3, hs on column 5.
  task automatic test_small_frames();
    logic [26:0] got, exp;
    int h, v;
    ce_b  = 1'b0;
    rst_b = 1'b1;
    step();
    rst_b = 1'b0;
    ce_b  = 1'b1;
    for (int k = 0; k < 70; k++) begin
      step();
      h = k % 7;
      v = (k / 7) % 5;
      got = {hc_s, vc_s, blank_s, hs_s, vs_s, ls_s, fs_s};
      exp = pack(h, v, !(h < 4 && v < 2), !(h == 5), !(v == 3), h == 0, h == 0 && v == 0);
      n_cmp++;
      if (got !== exp) begin
        n_err++;
        $display("FAIL small k=%0d got %h want %h", k, got, exp);
      end
`ifdef VGA_TIMING_PIXEL_ADDR_EN
      n_cmp++;
      if (pa_s !== 19'((v < 2) ? (v * 4 + ((h < 4) ? h : 4)) : 8)) begin
        n_err++;
        $display("FAIL addr_small k=%0d got %0d want %0d", k, pa_s,
                 (v < 2) ? (v * 4 + ((h < 4) ? h : 4)) : 8);
      end
`endif
    end
  endtask

  // Reset mid-frame on the small raster, then restart from (0,0).
  task automatic test_small_reset_mid();
    logic [26:0] got, exp;
    repeat (10) step();
    n_cmp++;
    if (hc_s !== 11'd2 || vc_s !== 11'd1) begin
      n_err++;
      $display("FAIL small_mid_pos got %0d,%0d want 2,1", hc_s, vc_s);
    end
    rst_b = 1'b1;
    #1;
    got = {hc_s, vc_s, blank_s, hs_s, vs_s, ls_s, fs_s};
    exp = pack(0, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL small_reset got %h want %h", got, exp);
    end
`ifdef VGA_TIMING_PIXEL_ADDR_EN
    n_cmp++;
    if (pa_s !== 19'd0) begin
      n_err++;
      $display("FAIL small_reset_addr got %0d want 0", pa_s);
    end
`endif
    step();
    rst_b = 1'b0;
    step();
    got = {hc_s, vc_s, blank_s, hs_s, vs_s, ls_s, fs_s};
    exp = pack(0, 0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL small_restart got %h want %h", got, exp);
    end
    ce_b = 1'b0;
  endtask

  initial begin
    test_reset();
    test_line();
    test_ce_quarter();
    test_reset_mid();
    test_small_frames();
    test_small_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
